// File: rtl/pixel_mem_server.sv
// Source/result frame memory server for a single pixel-processing core.
// Define PIXEL_MEM_DUMP_EN to stream the finished result frame on dump_val/dump_data.
module pixel_mem_server #(
  parameter int V_SIZE = 4,
  parameter int H_SIZE = 4,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_val,
  input  logic [23:0]       load_data,
  output logic              load_done,
  input  logic              rd_pixel,
  input  logic [ADDR_W-1:0] addr_pixel,
  output logic              pixel_val,
  output logic [23:0]       pixel_in,
  input  logic              wr_pixel,
  input  logic [23:0]       pixel_out,
  output logic              frame_done,
  output logic              rd_err,
  output logic              wr_err,
  output logic              dump_val,
  output logic [23:0]       dump_data
);

  localparam int IMG_SIZE = V_SIZE * H_SIZE;
  localparam int IDX_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(IMG_SIZE - 1);
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [23:0]       src_mem [IMG_SIZE];
  logic [23:0]       res_mem [IMG_SIZE];
  logic [ADDR_W-1:0] ld_ptr_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_busy_r;
  logic [2:0]        rd_cnt_r;
  logic              load_we_s;
  logic              res_we_s;
`ifdef PIXEL_MEM_DUMP_EN
  logic [ADDR_W-1:0] dump_ptr_r;
`else
  // RES is only observable through the dump stream.
  logic              unused_res_s;
  assign unused_res_s = ^res_mem[0];
`endif

  function automatic logic in_frame(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(IMG_SIZE));
  endfunction

  function automatic logic [23:0] src_word(input logic [ADDR_W-1:0] a);
    if (in_frame(a)) begin
      return src_mem[a[IDX_W-1:0]];
    end else begin
      return 24'h000000;
    end
  endfunction

  assign load_we_s = (state_r == ST_LOAD) && load_val;
  assign res_we_s  = (state_r == ST_SERVE) && wr_pixel;

  // Frame memories carry no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (load_we_s) begin
      src_mem[ld_ptr_r[IDX_W-1:0]] <= load_data;
    end
    if (res_we_s) begin
      res_mem[wr_ptr_r[IDX_W-1:0]] <= pixel_out;
    end
  end

  // Control FSM, read channel and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_LOAD;
      ld_ptr_r   <= {ADDR_W{1'b0}};
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_addr_r  <= {ADDR_W{1'b0}};
      rd_busy_r  <= 1'b0;
      rd_cnt_r   <= 3'd0;
      load_done  <= 1'b0;
      pixel_val  <= 1'b0;
      pixel_in   <= 24'h000000;
      frame_done <= 1'b0;
      rd_err     <= 1'b0;
      wr_err     <= 1'b0;
      dump_val   <= 1'b0;
      dump_data  <= 24'h000000;
`ifdef PIXEL_MEM_DUMP_EN
      dump_ptr_r <= {ADDR_W{1'b0}};
`endif
    end else begin
      pixel_val <= 1'b0;
      pixel_in  <= 24'h000000;
      dump_val  <= 1'b0;
      dump_data <= 24'h000000;

      // A read captured during LOAD stays frozen at count 0 until SERVE begins.
      if (rd_busy_r) begin
        if (rd_pixel) begin
          rd_err <= 1'b1;
        end
        if (state_r != ST_LOAD) begin
          if (rd_cnt_r == LAT_LAST) begin
            pixel_val <= 1'b1;
            pixel_in  <= src_word(rd_addr_r);
            rd_busy_r <= 1'b0;
          end else begin
            rd_cnt_r <= rd_cnt_r + 3'd1;
          end
        end
      end else if (rd_pixel) begin
        rd_addr_r <= addr_pixel;
        if (!in_frame(addr_pixel)) begin
          rd_err <= 1'b1;
        end
        if ((state_r != ST_LOAD) && (RD_LAT == 1)) begin
          pixel_val <= 1'b1;
          pixel_in  <= src_word(addr_pixel);
        end else begin
          rd_busy_r <= 1'b1;
          rd_cnt_r  <= (state_r == ST_LOAD) ? 3'd0 : 3'd1;
        end
      end

      case (state_r)
        ST_LOAD: begin
          if (wr_pixel) begin
            wr_err <= 1'b1;
          end
          if (load_val) begin
            if (ld_ptr_r == LAST_PTR) begin
              state_r   <= ST_SERVE;
              load_done <= 1'b1;
            end else begin
              ld_ptr_r <= ld_ptr_r + ADDR_W'(1);
            end
          end
        end
        ST_SERVE: begin
          if (wr_pixel) begin
            if (wr_ptr_r == LAST_PTR) begin
              frame_done <= 1'b1;
`ifdef PIXEL_MEM_DUMP_EN
              state_r    <= ST_DUMP;
`else
              state_r    <= ST_DONE;
`endif
            end else begin
              wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
          end
        end
`ifdef PIXEL_MEM_DUMP_EN
        ST_DUMP: begin
          if (wr_pixel) begin
            wr_err <= 1'b1;
          end
          dump_val  <= 1'b1;
          dump_data <= res_mem[dump_ptr_r[IDX_W-1:0]];
          if (dump_ptr_r == LAST_PTR) begin
            state_r <= ST_DONE;
          end else begin
            dump_ptr_r <= dump_ptr_r + ADDR_W'(1);
          end
        end
`endif
        ST_DONE: begin
          if (wr_pixel) begin
            wr_err <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_DONE;
          if (wr_pixel) begin
            wr_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_mem_server.sv
// Bench for pixel_mem_server: random frames and a grayscale core checked against a frame-level model.
`timescale 1ns/1ps
module tb_pixel_mem_server;

  localparam int N   = 16;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_val;
  logic [23:0] load_data;
  logic        load_done;
  logic        rd_pixel;
  logic [15:0] addr_pixel;
  logic        pixel_val;
  logic [23:0] pixel_in;
  logic        wr_pixel;
  logic [23:0] pixel_out;
  logic        frame_done;
  logic        rd_err;
  logic        wr_err;
  logic        dump_val;
  logic [23:0] dump_data;

  always #5 clk = ~clk;

  pixel_mem_server #(.V_SIZE(4), .H_SIZE(4), .ADDR_W(16), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .load_val(load_val), .load_data(load_data), .load_done(load_done),
    .rd_pixel(rd_pixel), .addr_pixel(addr_pixel),
    .pixel_val(pixel_val), .pixel_in(pixel_in),
    .wr_pixel(wr_pixel), .pixel_out(pixel_out),
    .frame_done(frame_done), .rd_err(rd_err), .wr_err(wr_err),
    .dump_val(dump_val), .dump_data(dump_data)
  );

  int checks = 0;
  int failures = 0;

  // Frame-level model: what the memories should hold and which errors have happened.
  logic [23:0] src_m [N];
  logic [23:0] res_m [N];
  int          wr_count;
  bit          loaded_m;
  bit          rd_err_m;
  bit          wr_err_m;

  function automatic logic [23:0] gray(input logic [23:0] p);
    return {p[23:16], p[23:16], p[23:16]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {load_done, pixel_val, pixel_in, frame_done, rd_err, wr_err, dump_val, dump_data}, 64'h0);
  endtask

  task automatic model_reset();
    wr_count = 0;
    loaded_m = 1'b0;
    rd_err_m = 1'b0;
    wr_err_m = 1'b0;
  endtask

  task automatic load_frame(input bit pattern);
    for (int i = 0; i < N; i++) begin
      src_m[i] = pattern ? (24'h010203 + 24'(i)) : 24'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        load_val = 1'b0;
        tick();
        chk("load_gap_done", load_done, 64'h0);
      end
      load_val  = 1'b1;
      load_data = src_m[i];
      tick();
      chk("load_done", load_done, (i == N - 1) ? 64'h1 : 64'h0);
      chk("load_no_pv", pixel_val, 64'h0);
    end
    load_val = 1'b0;
    loaded_m = 1'b1;
  endtask

  task automatic wait_read(input int start_k, input logic [23:0] exp, input string tag);
    int k;
    k = start_k;
    while (pixel_val !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(LAT));
    chk({tag, "_data"}, pixel_in, exp);
  endtask

  task automatic transact(input bit do_rd, input int addr, input bit do_wr,
                          input logic [23:0] wdata, input string tag);
    rd_pixel   = do_rd;
    addr_pixel = 16'(addr);
    wr_pixel   = do_wr;
    pixel_out  = wdata;
    tick();
    rd_pixel = 1'b0;
    wr_pixel = 1'b0;
    if (do_wr) begin
      if (loaded_m && wr_count < N) begin
        res_m[wr_count] = wdata;
        wr_count++;
      end else begin
        wr_err_m = 1'b1;
      end
    end
    if (do_rd && addr >= N) rd_err_m = 1'b1;
    chk({tag, "_frame_done"}, frame_done, (wr_count == N) ? 64'h1 : 64'h0);
    chk({tag, "_wr_err"}, wr_err, 64'(wr_err_m));
    if (do_rd) begin
      wait_read(1, (addr < N) ? src_m[addr] : 24'h000000, tag);
      chk({tag, "_rd_err"}, rd_err, 64'(rd_err_m));
    end
  endtask

  // Grayscale core: read pixel i while writing the result for pixel i-1.
  task automatic core_run(input int writes, input string tag);
    for (int i = 0; i < writes; i++) begin
      if (i == 0) begin
        transact(1'b1, i, 1'b0, 24'h000000, tag);
      end else begin
        transact(1'b1, i, 1'b1, gray(src_m[i-1]), tag);
      end
    end
    transact(1'b0, 0, 1'b1, gray(src_m[writes-1]), {tag, "_last"});
  endtask

  task automatic check_dump(input string tag);
`ifdef PIXEL_MEM_DUMP_EN
    chk({tag, "_pre"}, dump_val, 64'h0);
    for (int j = 0; j < N; j++) begin
      tick();
      chk({tag, "_val"}, dump_val, 64'h1);
      chk({tag, "_data"}, dump_data, res_m[j]);
    end
    tick();
    chk({tag, "_end"}, dump_val, 64'h0);
`else
    for (int j = 0; j <= N; j++) begin
      tick();
      chk({tag, "_tied"}, {dump_val, dump_data}, 64'h0);
    end
`endif
  endtask

  initial begin
    int a;
    reset = 1'b1; load_val = 1'b0; load_data = 24'h0; rd_pixel = 1'b0;
    addr_pixel = 16'h0; wr_pixel = 1'b0; pixel_out = 24'h0;
    model_reset();
    tick(); tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk_zero("post_reset");

    // Pattern load, directed read timing, back-to-back acceptance.
    load_frame(1'b1);
    chk("load_rest", {pixel_val, pixel_in, frame_done, rd_err, wr_err, dump_val, dump_data}, 64'h0);
    load_val = 1'b1; load_data = 24'hFFFFFF;
    tick();
    load_val = 1'b0;
    transact(1'b1, 5, 1'b0, 24'h0, "rd5");
    chk("rd5_value", pixel_in, 64'h010208);
    transact(1'b1, $urandom_range(0, N - 1), 1'b0, 24'h0, "rd_b2b");
    tick();
    chk("pv_pulse", pixel_val, 64'h0);
    repeat (4) transact(1'b1, $urandom_range(0, N - 1), 1'b0, 24'h0, "rd_rand");
    transact(1'b1, 16, 1'b0, 24'h0, "rd_oob");

    // Full frame through the grayscale core, then writes after completion.
    core_run(N, "coreA");
    check_dump("dumpA");
    transact(1'b0, 0, 1'b1, 24'($urandom), "extra_wr");
    transact(1'b1, 3, 1'b0, 24'h0, "rd_done");

    // Async reset, then a read pending across the load plus a busy collision.
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    a = $urandom_range(0, N - 1);
    rd_pixel = 1'b1; addr_pixel = 16'(a);
    tick();
    addr_pixel = 16'($urandom_range(0, N - 1));
    tick();
    rd_pixel = 1'b0;
    rd_err_m = 1'b1;
    chk("busy_rd_err", rd_err, 64'h1);
    load_frame(1'b0);
    wait_read(0, src_m[a], "pend");
    chk("pend_rd_err", rd_err, 64'h1);

    // Reset after 7 writes, then a clean reload and rerun.
    for (int i = 0; i < 7; i++) transact(1'b1, i, 1'b1, gray(src_m[i]), "partial");
    #2 reset = 1'b1;
    #1 chk_zero("mid_reset");
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk_zero("mid_reset_rel");
    transact(1'b0, 0, 1'b1, 24'h123456, "wr_in_load");
    load_frame(1'b0);
    core_run(N, "coreB");
    check_dump("dumpB");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pixel_mem_server.md
# pixel_mem_server

Frame-memory responder for the pixel-processing cores: it holds one source frame and answers the cores' `rd_pixel`/`addr_pixel` read requests with `pixel_val`/`pixel_in`. It also captures the cores' `wr_pixel`/`pixel_out` result stream into a result frame. It sits between the frame loader (testbench or DMA) and a single processing core such as the grayscale stage, and signals completion when a full result frame has been written.

## Interface
- `V_SIZE`, 4: frame rows.
- `H_SIZE`, 4: frame columns; `IMG_SIZE = V_SIZE*H_SIZE`.
- `ADDR_W`, 16: pixel address width; must satisfy `2**ADDR_W >= IMG_SIZE`.
- `RD_LAT`, 1: read latency in cycles, range 1..8.
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `load_val` in 1: source-frame load beat.
- `load_data` in 24: RGB pixel for the next sequential source address.
- `load_done` out 1: source frame fully loaded.
- `rd_pixel` in 1: core read request, single-cycle pulse.
- `addr_pixel` in ADDR_W: read address, sampled with `rd_pixel`.
- `pixel_val` out 1: read data valid, one-cycle pulse.
- `pixel_in` out 24: read data, valid only while `pixel_val`=1.
- `wr_pixel` in 1: core result write beat.
- `pixel_out` in 24: result pixel, stored at the next sequential result address.
- `frame_done` out 1: `IMG_SIZE` result pixels captured; sticky.
- `rd_err` out 1: sticky protocol error on the read side.
- `wr_err` out 1: sticky protocol error on the write side.
- `dump_val` out 1: result-frame dump beat.
- `dump_data` out 24: result pixel, address order.

## Operation
- Two `IMG_SIZE`x24 memories: SRC (written by load, read by core) and RES (written by core, read by dump). Memory contents are not cleared by reset.
- States:
  - LOAD: each `load_val` writes `load_data` to SRC[`ld_ptr`] and increments `ld_ptr`. After beat `IMG_SIZE-1`, go to SERVE and set `load_done`=1.
  - SERVE: reads and writes are served as described below. When the `IMG_SIZE`th write is accepted, set `frame_done`=1 and go to DUMP if dump is compiled in, else DONE.
  - DUMP: outputs RES[0..IMG_SIZE-1] one per cycle, then goes to DONE.
  - DONE: idle. Reads are still served. Writes are ignored and set `wr_err`.
- Reads:
  - One outstanding read at most. `rd_pixel`=1 while idle captures `addr_pixel` and sets busy.
  - Data returns `RD_LAT` cycles after capture with `pixel_val`=1 for one cycle. Busy clears in that same cycle, so a `rd_pixel` sampled on that edge is accepted.
  - `rd_pixel` while busy: ignored, `rd_err`=1.
  - `addr_pixel >= IMG_SIZE`: `pixel_in`=24'h000000 with normal latency, `rd_err`=1.
  - Read captured in LOAD: held pending. The latency count starts on the first SERVE cycle, so the core may request from reset and simply wait for `pixel_val`.
- Writes:
  - Accepted in SERVE only. Writes to RES[`wr_ptr`], then `wr_ptr`+1.
  - `wr_pixel` in LOAD, DUMP or DONE: ignored, `wr_err`=1.
- Simultaneous events:
  - Read and write in the same cycle are both accepted; the memories are independent.
  - `load_val` outside LOAD is ignored with no error.
- Reset, including mid-operation:
  - State LOAD; `ld_ptr`, `wr_ptr`, dump pointer and busy cleared; pending read dropped.
  - All outputs 0: `load_done`, `pixel_val`, `pixel_in`, `frame_done`, `rd_err`, `wr_err`, `dump_val`, `dump_data`.

## Timing
- Load: beat accepted on the edge where `load_val`=1. `load_done` rises on the edge accepting the last beat.
- Read: request sampled at edge N gives `pixel_val`/`pixel_in` registered at edge N+RD_LAT-1, visible for the cycle following that edge. With `RD_LAT`=1, data is visible the cycle right after the request cycle.
- Write: zero-wait. `frame_done` is registered on the edge accepting the last write.
- Dump: `dump_val` is high for exactly `IMG_SIZE` consecutive cycles, starting the cycle after `frame_done` rises.
- Pointer widths are ADDR_W. Pointers compare against `IMG_SIZE-1` and never wrap; the terminal transition replaces the increment.

## Configuration
- `PIXEL_MEM_DUMP_EN` defined: DUMP state and dump pointer are compiled in, and the result frame streams on `dump_val`/`dump_data` after `frame_done`.
- `PIXEL_MEM_DUMP_EN` not defined: SERVE goes directly to DONE. `dump_val`/`dump_data` are tied to 0; the ports remain present.

## Test plan
- Reset, then load 16 pixels 24'h010203+i (4x4) -> `load_done`=1 after the 16th beat; all other outputs 0.
- Read addr 5 with `RD_LAT`=3 -> `pixel_val` for one cycle, 3 cycles after the request, with `pixel_in`=24'h010208. Second request sampled on the `pixel_val` cycle -> accepted, `rd_err`=0.
- `rd_pixel` issued during LOAD, and a back-to-back `rd_pixel` while busy -> first is answered after load completes; second is ignored with `rd_err`=1. Read of addr 16 -> 24'h000000 with `rd_err`=1.
- Connect the grayscale core and run a full 4x4 frame -> `frame_done`=1 after 16 writes; RES[i]={R,R,R} of SRC[i]. With `PIXEL_MEM_DUMP_EN`, 16 consecutive `dump_val` beats in address order.
- Extra `wr_pixel` after `frame_done` -> ignored, `wr_err`=1, RES unchanged.
- Assert `reset` after 7 writes -> all outputs 0 next cycle, state LOAD. Reload and rerun -> `frame_done` after exactly 16 new writes.
